pio_input_conditioner: RTL

- Conditions one raw asynchronous input (pushbutton / GPIO) before it drives the `in_port` of the single-bit Avalon input PIO in the bridge subsystem.
- Provides:
  - a metastability synchronizer;
  - a counter-based debouncer with a small state machine;
  - one-cycle edge pulses;
  - a wrapping rising-edge event counter for software diagnostics.
- Output `level_out` connects directly to the PIO `in_port`.

---
 rtl/pio_input_conditioner.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pio_input_conditioner.sv
// -----------------------------------------------------------------------------
// pio_input_conditioner
//
// Conditions one raw asynchronous input (pushbutton / GPIO) before it drives
// the in_port of a single-bit Avalon input PIO. The input passes through a
// metastability synchronizer and then a counter-based debouncer. Committed
// level changes produce one-cycle edge pulses, and rising commits are counted
// in a wrapping event counter for software diagnostics.
//
// Parameters:
//   SYNC_STAGES     synchronizer depth (legal 2..4)
//   DEBOUNCE_CYCLES consecutive cycles a new level must persist (legal >= 1)
//   EVENT_W         width of the rising-edge event counter
//   INIT_LEVEL      reset value of the synchronizer flops and level_out
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   asynchronous, active-high reset
//   raw_in       in   unsynchronized external input
//   count_clr    in   synchronous clear of event_count (one-cycle pulse)
//   level_out    out  debounced level, feeds PIO in_port
//   rise_pulse   out  one-cycle pulse on a committed 0->1
//   fall_pulse   out  one-cycle pulse on a committed 1->0
//   stable       out  1 when the debounce FSM is in STABLE (FSM state view)
//   event_count  out  committed rising edges, wrapping
//
// Optional feature, macro CONDITIONER_EDGE_IRQ_EN:
//   edge_clear   in   clears edge_capture (one-cycle pulse)
//   edge_capture out  sticky flag set by rise_pulse; set wins over clear
//   irq          out  equal to edge_capture
//   With the macro undefined these ports and the capture flop do not exist.
//
// Handshake: there is no valid/ready interface. count_clr and edge_clear are
// single-cycle strobes sampled on the rising edge of clk; pulses are
// registered and last exactly one cycle.
// -----------------------------------------------------------------------------
module pio_input_conditioner #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EVENT_W         = 16,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               raw_in,
  input  logic               count_clr,
`ifdef CONDITIONER_EDGE_IRQ_EN
  input  logic               edge_clear,
  output logic               edge_capture,
  output logic               irq,
`endif
  output logic               level_out,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic               stable,
  output logic [EVENT_W-1:0] event_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the first mismatch already satisfies the
  // persistence requirement, so STABLE commits directly.
  localparam logic IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  // Synchronizer
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;

  // Debouncer
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_level;
  logic                   w_level_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   r_fall;
  logic                   w_fall_nxt;
  logic                   r_stable;
  logic                   w_mismatch;
  logic                   w_commit;

  // Event counter
  logic [EVENT_W-1:0]     r_event;
  logic [EVENT_W-1:0]     w_event_nxt;

  // ---------------------------------------------------------------------------
  // Synchronizer: plain shift chain, no logic between stages.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_sync_out != r_level);

  // A commit happens once the mismatch has been seen for DEBOUNCE_CYCLES
  // consecutive cycles: the counter already holds DEBOUNCE_CYCLES-1.
  assign w_commit = w_mismatch &&
                    (((r_state == ST_STABLE) && IMMEDIATE) ||
                     ((r_state == ST_QUALIFY) && (r_cnt == CNT_LAST)));

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_STABLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STABLE: begin
        if (w_mismatch && !w_commit) begin
          w_state_nxt = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        // Bounce back or a completed qualification both return to STABLE.
        if (!w_mismatch || w_commit) begin
          w_state_nxt = ST_STABLE;
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (w_commit) begin
      w_level_nxt = w_sync_out;
      w_rise_nxt  = w_sync_out;
      w_fall_nxt  = ~w_sync_out;
    end else if (w_mismatch) begin
      // Entering QUALIFY counts the first mismatch cycle as 1.
      w_cnt_nxt = (r_state == ST_QUALIFY) ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
    end
  end

  // count_clr has priority over an increment landing in the same cycle.
  always_comb begin
    w_event_nxt = r_event;
    if (count_clr) begin
      w_event_nxt = '0;
    end else if (w_rise_nxt) begin
      w_event_nxt = r_event + EVENT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_level  <= INIT_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_stable <= 1'b1;
      r_event  <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_stable <= (w_state_nxt == ST_STABLE);
      r_event  <= w_event_nxt;
    end
  end

  assign level_out   = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign stable      = r_stable;
  assign event_count = r_event;

`ifdef CONDITIONER_EDGE_IRQ_EN
  // ---------------------------------------------------------------------------
  // Sticky rising-edge capture; a rise in the same cycle as a clear wins.
  // ---------------------------------------------------------------------------
  logic r_edge_capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_capture <= 1'b0;
    end else if (r_rise) begin
      r_edge_capture <= 1'b1;
    end else if (edge_clear) begin
      r_edge_capture <= 1'b0;
    end
  end

  assign edge_capture = r_edge_capture;
  assign irq          = r_edge_capture;
`endif

endmodule
